// File: rtl/axis_write_2d.sv
// axis_write_2d: writes an AXI-Stream into memory as a 2D strided region over AXI4 write bursts.
// Define AXIS_WRITE_2D_BRESP_EN to track B responses (RESP state, sticky error); otherwise bready=1, error=0.
module axis_write_2d #(
  parameter int CONFIG_ID      = 1,
  parameter int CONFIG_ADDR    = 23,
  parameter int CONFIG_DATA    = 24,
  parameter int CONFIG_AWIDTH  = 5,
  parameter int CONFIG_DWIDTH  = 32,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int BURST_MAX      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CONFIG_AWIDTH-1:0]  cfg_addr,
  input  logic [CONFIG_DWIDTH-1:0]  cfg_data,
  input  logic                      cfg_valid,
  output logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
  output logic [AXI_LEN_WIDTH-1:0]  axi_awlen,
  output logic                      axi_awvalid,
  input  logic                      axi_awready,
  output logic [AXI_DATA_WIDTH-1:0] axi_wdata,
  output logic                      axi_wlast,
  output logic                      axi_wvalid,
  input  logic                      axi_wready,
  input  logic [1:0]                axi_bresp,
  input  logic                      axi_bvalid,
  output logic                      axi_bready,
  input  logic [AXI_DATA_WIDTH-1:0] data,
  input  logic                      valid,
  output logic                      ready,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);

  localparam int BYTE_SHIFT = $clog2(AXI_DATA_WIDTH / 8);
  localparam int CNT_W      = $clog2(BURST_MAX) + 1;

  typedef enum logic [2:0] {IDLE, CONFIG, ADDR, DATA, RESP, DONE} state_t;
  state_t state;

  logic [CONFIG_AWIDTH-1:0]  cfg_addr_q;
  logic [CONFIG_DWIDTH-1:0]  cfg_data_q;
  logic                      cfg_valid_q;
  logic [1:0]                word_idx;
  logic [AXI_ADDR_WIDTH-1:0] row_base, cur_addr, stride;
  logic [CONFIG_DWIDTH-1:0]  row_len, rows_left, beats_left;
  logic [CNT_W-1:0]          beat_cnt, burst_beats;
  logic [12:0]               page_left;
  logic [CONFIG_DWIDTH-1:0]  beats_to_page, burst_sel;
  logic                      cmd_hit, word_hit, w_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      cfg_valid_q <= 1'b0;
    end else begin
      cfg_addr_q  <= cfg_addr;
      cfg_data_q  <= cfg_data;
      cfg_valid_q <= cfg_valid;
    end
  end

  assign cmd_hit  = cfg_valid_q && cfg_addr_q == CONFIG_AWIDTH'(CONFIG_ADDR)
                    && cfg_data_q == CONFIG_DWIDTH'(CONFIG_ID);
  assign word_hit = cfg_valid_q && cfg_addr_q == CONFIG_AWIDTH'(CONFIG_DATA);
  assign w_fire   = (state == DATA) && valid && axi_wready;

  // Burst size is the smallest of the cap, the rest of the row and the room left in the 4 KB page.
  always_comb begin
    page_left     = 13'd4096 - {1'b0, cur_addr[11:0]};
    beats_to_page = CONFIG_DWIDTH'(page_left >> BYTE_SHIFT);
    burst_sel     = CONFIG_DWIDTH'(BURST_MAX);
    if (beats_left < burst_sel) burst_sel = beats_left;
    if (beats_to_page < burst_sel) burst_sel = beats_to_page;
    burst_beats   = burst_sel[CNT_W-1:0];
  end

  assign axi_awaddr = cur_addr;
  assign axi_awlen  = AXI_LEN_WIDTH'(burst_beats - 1'b1);
  assign axi_wdata  = data;
  assign axi_wvalid = (state == DATA) && valid;
  assign ready      = (state == DATA) && axi_wready;
  assign axi_wlast  = (state == DATA) && beat_cnt == CNT_W'(1);

`ifdef AXIS_WRITE_2D_BRESP_EN
  logic [15:0] outstanding;
  logic        aw_fire, b_fire, unused_bresp;

  assign aw_fire      = axi_awvalid && axi_awready;
  assign b_fire       = axi_bvalid && axi_bready;
  assign axi_bready   = busy;
  assign unused_bresp = axi_bresp[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      error       <= 1'b0;
    end else begin
      if (aw_fire && !b_fire) outstanding <= outstanding + 16'd1;
      else if (b_fire && !aw_fire) outstanding <= outstanding - 16'd1;
      if (state == IDLE && cmd_hit) error <= 1'b0;
      else if (b_fire && axi_bresp[1]) error <= 1'b1;
    end
  end
`else
  logic unused_b;
  assign axi_bready = 1'b1;
  assign error      = 1'b0;
  assign unused_b   = ^{axi_bresp, axi_bvalid};
`endif

  // Control FSM; busy, done and awvalid are set on the transition into their state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      axi_awvalid <= 1'b0;
      word_idx    <= '0;
      row_base    <= '0;
      cur_addr    <= '0;
      stride      <= '0;
      row_len     <= '0;
      rows_left   <= '0;
      beats_left  <= '0;
      beat_cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (cmd_hit) begin
          state    <= CONFIG;
          busy     <= 1'b1;
          word_idx <= '0;
        end
        CONFIG: if (word_hit) begin
          word_idx <= word_idx + 2'd1;
          case (word_idx)
            2'd0: row_base  <= AXI_ADDR_WIDTH'(cfg_data_q);
            2'd1: row_len   <= cfg_data_q;
            2'd2: rows_left <= cfg_data_q;
            default: begin
              stride     <= AXI_ADDR_WIDTH'(cfg_data_q);
              cur_addr   <= row_base;
              beats_left <= row_len;
              if (row_len == '0 || rows_left == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state       <= ADDR;
                axi_awvalid <= 1'b1;
              end
            end
          endcase
        end
        ADDR: if (axi_awready) begin
          axi_awvalid <= 1'b0;
          beat_cnt    <= burst_beats;
          cur_addr    <= cur_addr + (AXI_ADDR_WIDTH'(burst_beats) << BYTE_SHIFT);
          beats_left  <= beats_left - CONFIG_DWIDTH'(burst_beats);
          state       <= DATA;
        end
        DATA: if (w_fire) begin
          beat_cnt <= beat_cnt - 1'b1;
          if (beat_cnt == CNT_W'(1)) begin
            if (beats_left != '0) begin
              state       <= ADDR;
              axi_awvalid <= 1'b1;
            end else if (rows_left != CONFIG_DWIDTH'(1)) begin
              rows_left   <= rows_left - 1'b1;
              row_base    <= row_base + stride;
              cur_addr    <= row_base + stride;
              beats_left  <= row_len;
              state       <= ADDR;
              axi_awvalid <= 1'b1;
            end else begin
`ifdef AXIS_WRITE_2D_BRESP_EN
              state <= RESP;
`else
              state <= DONE;
              done  <= 1'b1;
`endif
            end
          end
        end
`ifdef AXIS_WRITE_2D_BRESP_EN
        RESP: if (outstanding == '0) begin
          state <= DONE;
          done  <= 1'b1;
        end
`endif
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
